// File: rtl/zbuf_pkg.sv
// Shared definitions for the z-buffer / span-fill blocks.
package zbuf_pkg;

  // Default coordinate and colour-channel widths.
  localparam int unsigned COORD_W = 8;
  localparam int unsigned CH_W    = 8;

  // Field offsets inside a 24-bit {x, y, z} point.
  localparam int unsigned PT_X_MSB = 23;
  localparam int unsigned PT_X_LSB = 16;
  localparam int unsigned PT_Y_MSB = 15;
  localparam int unsigned PT_Y_LSB = 8;
  localparam int unsigned PT_Z_MSB = 7;
  localparam int unsigned PT_Z_LSB = 0;

  // Span-fill sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } fill_state_e;

endpackage

// File: rtl/bresenham_fill.sv
// Horizontal span filler: writes one colour to every pixel between two x
// endpoints on a shared row, lowest x first, then pulses ack_2 low.
module bresenham_fill #(
  parameter int unsigned COORD_W = zbuf_pkg::COORD_W,
  parameter int unsigned CH_W    = zbuf_pkg::CH_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_2,
  output logic                 ack_2,
  input  logic [COORD_W-1:0]   point_out_a_x,
  input  logic [2*COORD_W-1:0] point_out_b_xy,
  input  logic [3*CH_W-1:0]    rgb,
  output logic [CH_W-1:0]      rdata,
  output logic [CH_W-1:0]      gdata,
  output logic [CH_W-1:0]      bdata,
  output logic [2*COORD_W-1:0] waddr,
  output logic                 we
);

  import zbuf_pkg::*;

  fill_state_e        state_q;
  logic [COORD_W-1:0] x_cur_q;
  logic [COORD_W-1:0] x_end_q;
  logic [COORD_W-1:0] y_q;

  logic [COORD_W-1:0] xb;
  logic [COORD_W-1:0] y_in;
  logic [COORD_W-1:0] x_lo;
  logic [COORD_W-1:0] x_hi;
  logic [COORD_W-1:0] x_next;

  // Endpoint ordering so the fill always runs upward in x.
  always_comb begin
    xb     = point_out_b_xy[2*COORD_W-1:COORD_W];
    y_in   = point_out_b_xy[COORD_W-1:0];
    x_lo   = (point_out_a_x < xb) ? point_out_a_x : xb;
    x_hi   = (point_out_a_x < xb) ? xb : point_out_a_x;
    x_next = x_cur_q + 1'b1;
  end

  // Sequencer with registered outputs; the first write is set up at the latch
  // edge so it is visible in the very first FILL cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      x_cur_q <= '0;
      x_end_q <= '0;
      y_q     <= '0;
      we      <= 1'b0;
      ack_2   <= 1'b1;
      waddr   <= '0;
      rdata   <= '0;
      gdata   <= '0;
      bdata   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ack_2 <= 1'b1;
          if (!req_2) begin
            x_cur_q <= x_lo;
            x_end_q <= x_hi;
            y_q     <= y_in;
            rdata   <= rgb[3*CH_W-1:2*CH_W];
            gdata   <= rgb[2*CH_W-1:CH_W];
            bdata   <= rgb[CH_W-1:0];
            waddr   <= {y_in, x_lo};
            we      <= 1'b1;
            state_q <= StFill;
          end
        end
        StFill: begin
          // End compare comes before the increment, so x_cur never wraps.
          if (x_cur_q == x_end_q) begin
            we      <= 1'b0;
            ack_2   <= 1'b0;
            state_q <= StDone;
          end else begin
            x_cur_q <= x_next;
            waddr   <= {y_q, x_next};
          end
        end
        StDone: begin
          ack_2   <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          we      <= 1'b0;
          ack_2   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bresenham_fill.sv
// Directed bench for bresenham_fill: table of spans plus reset-abort sequence.
module tb_bresenham_fill;

  logic        clk;
  logic        rst;
  logic        req_2;
  logic        ack_2;
  logic [7:0]  point_out_a_x;
  logic [15:0] point_out_b_xy;
  logic [23:0] rgb;
  logic [7:0]  rdata;
  logic [7:0]  gdata;
  logic [7:0]  bdata;
  logic [15:0] waddr;
  logic        we;

  int n_vec  = 0;
  int n_fail = 0;

  bresenham_fill #(
    .COORD_W(8),
    .CH_W   (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_2         (req_2),
    .ack_2         (ack_2),
    .point_out_a_x (point_out_a_x),
    .point_out_b_xy(point_out_b_xy),
    .rgb           (rgb),
    .rdata         (rdata),
    .gdata         (gdata),
    .bdata         (bdata),
    .waddr         (waddr),
    .we            (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  xa;
    logic [15:0] bxy;
    logic [23:0] rgb;
    logic [15:0] first_addr;
    int          n;
    bit          req_mid;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Must be called at a negedge. Issues a one-cycle request, then follows the
  // span write by write until ack_2 and checks the quiet cycle after it.
  task automatic run_span(input vec_t v);
    int          writes;
    int          cyc;
    int          ack_cyc;
    bit          got_ack;
    logic [15:0] exp_addr;
    writes   = 0;
    cyc      = 0;
    ack_cyc  = -1;
    got_ack  = 1'b0;
    exp_addr = v.first_addr;
    point_out_a_x  = v.xa;
    point_out_b_xy = v.bxy;
    rgb            = v.rgb;
    req_2          = 1'b0;
    @(negedge clk);
    req_2 = 1'b1;
    // Scramble inputs: only latched values may be used.
    point_out_a_x  = 8'hC3;
    point_out_b_xy = 16'h5A11;
    rgb            = 24'h0F0F0F;
    check("first_write_latency", {31'd0, we}, 32'd1);
    while (!got_ack && cyc < 300) begin
      if (v.req_mid && writes == 3) req_2 = 1'b0;
      if (v.req_mid && writes == 5) req_2 = 1'b1;
      if (we === 1'b1) begin
        check("waddr", {16'd0, waddr}, {16'd0, exp_addr});
        check("rgb_data", {8'd0, rdata, gdata, bdata}, {8'd0, v.rgb});
        writes++;
        exp_addr = exp_addr + 16'd1;
      end
      if (ack_2 === 1'b0) begin
        got_ack = 1'b1;
        ack_cyc = cyc;
        check("we_low_at_ack", {31'd0, we}, 32'd0);
      end
      cyc++;
      if (!got_ack) @(negedge clk);
    end
    req_2 = 1'b1;
    check("ack_seen", {31'd0, got_ack}, 32'd1);
    check("write_count", writes, v.n);
    check("ack_latency", ack_cyc, v.n);
    @(negedge clk);
    check("ack_one_cycle", {31'd0, ack_2}, 32'd1);
    check("we_idle", {31'd0, we}, 32'd0);
    @(negedge clk);
    check("no_restart", {31'd0, we}, 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{xa: 8'h86, bxy: 16'h9090, rgb: 24'hFFFFFF, first_addr: 16'h9086, n: 11,
                req_mid: 1'b0};
    vecs[1] = '{xa: 8'h90, bxy: 16'h8690, rgb: 24'h123456, first_addr: 16'h9086, n: 11,
                req_mid: 1'b0};
    vecs[2] = '{xa: 8'h25, bxy: 16'h2535, rgb: 24'hA0B0C0, first_addr: 16'h3525, n: 1,
                req_mid: 1'b0};
    vecs[3] = '{xa: 8'h00, bxy: 16'hFF07, rgb: 24'h010203, first_addr: 16'h0700, n: 256,
                req_mid: 1'b0};
    vecs[4] = '{xa: 8'h40, bxy: 16'h4A11, rgb: 24'h00FF00, first_addr: 16'h1140, n: 11,
                req_mid: 1'b1};

    rst            = 1'b0;
    req_2          = 1'b1;
    point_out_a_x  = 8'h00;
    point_out_b_xy = 16'h0000;
    rgb            = 24'h000000;
    #12;
    check("reset_we", {31'd0, we}, 32'd0);
    check("reset_ack", {31'd0, ack_2}, 32'd1);
    check("reset_waddr", {16'd0, waddr}, 32'd0);
    check("reset_data", {8'd0, rdata, gdata, bdata}, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_span(vecs[i]);

    // Reset mid-span after three writes: abort immediately, no ack.
    point_out_a_x  = 8'h10;
    point_out_b_xy = 16'h2020;
    rgb            = 24'h445566;
    req_2          = 1'b0;
    @(negedge clk);
    req_2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_abort_addr", {16'd0, waddr}, 32'h0000_2012);
    #2;
    rst = 1'b0;
    #1;
    check("abort_we", {31'd0, we}, 32'd0);
    check("abort_ack", {31'd0, ack_2}, 32'd1);
    check("abort_waddr", {16'd0, waddr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("abort_still_quiet", {30'd0, we, ack_2}, 32'd1);
    // Release reset and request on the very first edge afterwards.
    rst = 1'b1;
    run_span('{xa: 8'h03, bxy: 16'h0155, rgb: 24'h778899, first_addr: 16'h5501, n: 3,
               req_mid: 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
